// File: rtl/io_select_sequencer_pkg.sv
// Shared types and helpers for the I/O chip-select sequencer.
package io_select_sequencer_pkg;

  localparam int NDEV  = 8;
  localparam int DEV_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  // Active-low one-of-eight decode; a disabled decode leaves every select high.
  function automatic logic [NDEV-1:0] sel_n(input logic [DEV_W-1:0] idx, input logic en);
    logic [NDEV-1:0] s;
    s = '1;
    if (en) s[idx] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/io_select_sequencer_if.sv
// Requester-side bus bundle: request, target device, direction, grant and ack.
interface io_select_sequencer_if #(
  parameter int NREQ = 4
);
  import io_select_sequencer_pkg::*;

  logic [NREQ-1:0]       req;
  logic [DEV_W*NREQ-1:0] dev;
  logic [NREQ-1:0]       wr;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;

  modport master (output req, dev, wr, input gnt, ack);
  modport slave  (input req, dev, wr, output gnt, ack);

endinterface

// File: rtl/io_select_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module io_select_sequencer_rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // Scanning from the farthest offset down lets the nearest set bit overwrite the rest.
  always_comb begin
    logic [IDX_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(ptr) + i) % NREQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_select_sequencer.sv
// Arbitrates requesters onto one active-low chip-select decode and sequences
// each access as setup, strobe (programmable width), hold and turnaround.
module io_select_sequencer
  import io_select_sequencer_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WAIT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  io_select_sequencer_if.slave    bus,
  input  logic [NDEV*WAIT_W-1:0]  wait_cfg,
  output logic [NDEV-1:0]         cs_n,
  output logic                    rd_n,
  output logic                    wr_n,
  output logic                    busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state, next_state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner_q;
  logic [DEV_W-1:0]   dev_q;
  logic               wr_q;
  logic [WAIT_W-1:0]  count, count_next;
  logic [NREQ-1:0]    gnt_q, ack_q;

  logic [IDX_W-1:0]   arb_winner;
  logic               arb_valid;
  logic [DEV_W-1:0]   arb_dev;
  logic               arb_wr;
  logic [WAIT_W-1:0]  arb_wait;
  logic [IDX_W-1:0]   ptr_next;
  logic               load;

  logic [IDX_W-1:0]   winner_n;
  logic [DEV_W-1:0]   dev_n;
  logic               wr_n_src;
  logic [NREQ-1:0]    gnt_d, ack_d;
  logic               cs_en, rd_d, wr_d;

  io_select_sequencer_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  assign arb_dev  = bus.dev[DEV_W*int'(arb_winner) +: DEV_W];
  assign arb_wr   = bus.wr[arb_winner];
  assign arb_wait = wait_cfg[WAIT_W*int'(arb_dev) +: WAIT_W];
  assign ptr_next = (arb_winner == IDX_W'(NREQ - 1)) ? '0 : arb_winner + IDX_W'(1);

  assign bus.gnt = gnt_q;
  assign bus.ack = ack_q;

  // Next-state logic; outputs are decoded from the next state so they can be registered.
  always_comb begin
    next_state = state;
    count_next = count;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          next_state = SETUP;
          load       = 1'b1;
          count_next = arb_wait;
        end
      end
      SETUP:  next_state = STROBE;
      STROBE: begin
        if (count == '0) next_state = HOLD;
        else             count_next = count - WAIT_W'(1);
      end
      HOLD:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    winner_n = load ? arb_winner : winner_q;
    dev_n    = load ? arb_dev    : dev_q;
    wr_n_src = load ? arb_wr     : wr_q;
    gnt_d    = '0;
    ack_d    = '0;
    cs_en    = 1'b0;
    rd_d     = 1'b1;
    wr_d     = 1'b1;
    unique case (next_state)
      SETUP: begin
        gnt_d = NREQ'(1) << winner_n;
        cs_en = 1'b1;
      end
      STROBE: begin
        gnt_d = NREQ'(1) << winner_n;
        cs_en = 1'b1;
        rd_d  = wr_n_src;
        wr_d  = ~wr_n_src;
      end
      HOLD: begin
        gnt_d = NREQ'(1) << winner_n;
        ack_d = NREQ'(1) << winner_n;
        cs_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      winner_q <= '0;
      dev_q    <= '0;
      wr_q     <= 1'b0;
      count    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      cs_n     <= '1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state <= next_state;
      count <= count_next;
      if (load) begin
        winner_q <= arb_winner;
        dev_q    <= arb_dev;
        wr_q     <= arb_wr;
        ptr      <= ptr_next;
      end
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      cs_n  <= sel_n(dev_n, cs_en);
      rd_n  <= rd_d;
      wr_n  <= wr_d;
      busy  <= (next_state != IDLE);
    end
  end

endmodule
